fp16_sub_pipe: RTL

//  Pipelined IEEE-754 half-precision subtractor: o_res = i_a - i_b.

---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_lzc.sv | 12 +
 rtl/fp16_sub_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, operand record and special-case tag for the FFT butterfly arithmetic.
package fp16_pkg;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int FP_W    = 1 + EXP_W + MAN_W;
    localparam int EXP_MAX = 2 * BIAS + 1;

    localparam logic [FP_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP_W-1:0] FP16_PINF = 16'h7C00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_op_t;

    typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF, SP_NAN} spec_t;

    // Denormals take effective exponent 1 so they align with the smallest normal.
    function automatic fp_op_t fp_unpack(input logic [FP_W-1:0] v, input logic neg);
        fp_op_t o;
        o.sign = v[FP_W-1] ^ neg;
        o.exp  = (v[FP_W-2:MAN_W] == '0) ? EXP_W'(1) : v[FP_W-2:MAN_W];
        o.man  = {|v[FP_W-2:MAN_W], v[MAN_W-1:0]};
        return o;
    endfunction
endpackage

// File: rtl/fp16_lzc.sv
// 12-bit leading-zero counter used by the normalize stage; all-zero input yields 12.
module fp16_lzc (
    input  logic [11:0] i_val,
    output logic [3:0]  o_cnt
);
    always_comb begin
        o_cnt = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (i_val[i]) o_cnt = 4'(11 - i);
        end
    end
endmodule

// File: rtl/fp16_sub_pipe.sv
// Three-stage FP16 subtractor (a - b) with truncation and valid/ready stall; difference leg of the FFT butterfly.
module fp16_sub_pipe
    import fp16_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [FP_W-1:0] i_a,
    input  logic [FP_W-1:0] i_b,
    input  logic            i_vld,
    output logic            o_rdy,
    input  logic            i_rdy,
    output logic [FP_W-1:0] o_res,
    output logic            o_res_vld,
    output logic            overflow
);
    logic       w_en;
    logic [3:1] r_vld_pipe;

    assign w_en      = ~o_res_vld | i_rdy;
    assign o_rdy     = w_en;
    assign o_res_vld = r_vld_pipe[3];

    // ---------------- S1: unpack / align / specials ----------------
    fp_op_t           w_a, w_b, w_l, w_s;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_a_ge;
    logic [EXP_W-1:0] w_ediff;
    logic [3:0]       w_shamt;
    logic [11:0]      w_ms;
    spec_t            w_tag;
    logic [FP_W-1:0]  w_sval;

    assign w_a      = fp_unpack(i_a, 1'b0);
    assign w_b      = fp_unpack(i_b, 1'b1);
    assign w_a_nan  = (&i_a[14:10]) & (|i_a[9:0]);
    assign w_b_nan  = (&i_b[14:10]) & (|i_b[9:0]);
    assign w_a_inf  = (&i_a[14:10]) & ~(|i_a[9:0]);
    assign w_b_inf  = (&i_b[14:10]) & ~(|i_b[9:0]);
    assign w_a_zero = ~(|i_a[14:0]);
    assign w_b_zero = ~(|i_b[14:0]);
    assign w_a_ge   = i_a[14:0] >= i_b[14:0];
    assign w_l      = w_a_ge ? w_a : w_b;
    assign w_s      = w_a_ge ? w_b : w_a;
    assign w_ediff  = w_l.exp - w_s.exp;
    assign w_shamt  = (w_ediff > 5'd12) ? 4'd12 : w_ediff[3:0];
    assign w_ms     = {1'b0, w_s.man} >> w_shamt;

    always_comb begin
        w_tag  = SP_NONE;
        w_sval = '0;
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (i_a[15] == i_b[15]))) begin
            w_tag  = SP_NAN;
            w_sval = FP16_QNAN;
        end else if (w_a_inf) begin
            w_tag  = SP_INF;
            w_sval = i_a;
        end else if (w_b_inf) begin
            w_tag  = SP_INF;
            w_sval = {~i_b[15], i_b[14:0]};
        end else if (w_a_zero & w_b_zero) begin
            w_tag  = SP_ZERO;
            w_sval = {i_a[15] & ~i_b[15], 15'h0};
        end
    end

    spec_t            r1_tag, r2_tag;
    logic [FP_W-1:0]  r1_val, r2_val;
    logic             r1_sign, r2_sign, r1_sub;
    logic [EXP_W-1:0] r1_exp, r2_exp;
    logic [11:0]      r1_ml, r1_ms, r2_mag;

    // ---------------- S3: normalize / pack ----------------
    logic [3:0]       w_lzc;
    logic [4:0]       w_sh, w_lim;
    logic [10:0]      w_norm;
    logic [5:0]       w_exp6;
    logic             w_sign, w_ovf;
    logic [FP_W-1:0]  w_res;

    fp16_lzc u_lzc (
        .i_val (r2_mag),
        .o_cnt (w_lzc)
    );

    always_comb begin
        w_sh   = '0;
        w_norm = '0;
        w_exp6 = '0;
        w_ovf  = 1'b0;
        w_lim  = r2_exp - 5'd1;
        w_sign = r2_sign & (r2_mag != '0);
        if (r2_mag[11]) begin
            w_norm = r2_mag[11:1];
            w_exp6 = {1'b0, r2_exp} + 6'd1;
        end else begin
            // Hidden bit lives at [10], so one leading zero is expected; never drop below exp 1.
            w_sh = {1'b0, w_lzc} - 5'd1;
            if (w_sh > w_lim) w_sh = w_lim;
            w_norm = 11'(r2_mag << w_sh);
            w_exp6 = w_norm[10] ? {1'b0, r2_exp - w_sh} : 6'd0;
        end
        w_res = {w_sign, w_exp6[4:0], w_norm[9:0]};
        if (r2_tag != SP_NONE) begin
            w_res = r2_val;
            w_ovf = (r2_tag == SP_INF) | (r2_tag == SP_NAN);
        end else if (w_exp6 >= 6'(EXP_MAX)) begin
            w_res = {w_sign, FP16_PINF[14:0]};
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r1_tag     <= SP_NONE;
            r1_val     <= '0;
            r1_sign    <= 1'b0;
            r1_sub     <= 1'b0;
            r1_exp     <= '0;
            r1_ml      <= '0;
            r1_ms      <= '0;
            r2_tag     <= SP_NONE;
            r2_val     <= '0;
            r2_sign    <= 1'b0;
            r2_exp     <= '0;
            r2_mag     <= '0;
            o_res      <= '0;
            overflow   <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe <= {r_vld_pipe[2:1], i_vld};
            r1_tag     <= w_tag;
            r1_val     <= w_sval;
            r1_sign    <= w_l.sign;
            r1_sub     <= w_l.sign ^ w_s.sign;
            r1_exp     <= w_l.exp;
            r1_ml      <= {1'b0, w_l.man};
            r1_ms      <= w_ms;
            r2_tag     <= r1_tag;
            r2_val     <= r1_val;
            r2_sign    <= r1_sign;
            r2_exp     <= r1_exp;
            r2_mag     <= r1_sub ? (r1_ml - r1_ms) : (r1_ml + r1_ms);
            o_res      <= w_res;
            overflow   <= w_ovf;
        end
    end
endmodule
